// File: rtl/keypad_encoder_if.sv
// Keypad bus between the keypad encoder and the watch, timer and alarm-set logic.
// The master side is the encoder: it takes the raw contacts and drives the events.
// The slave side is a consumer of the events, or the source that supplies the contacts.
interface keypad_encoder_if;
    logic [9:0] key_raw;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_repeat;
    logic       multi_err;

    modport master (
        input  key_raw,
        output keypad,
        output key_code,
        output key_valid,
        output key_held,
        output key_repeat,
        output multi_err
    );

    modport slave (
        output key_raw,
        input  keypad,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  key_repeat,
        input  multi_err
    );
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder: 10-key keypad front end running on the 1 kHz system clock.
// The block synchronizes and debounces the raw contacts and rejects presses of
// more than one key. Each physical press produces one one-hot keypad pulse and
// a BCD key code.
// Optional build macro KEYPAD_REPEAT_EN: while a key stays held, the block
// emits auto-repeat pulses after REPEAT_DELAY cycles and then every
// REPEAT_RATE cycles. When the macro is undefined, key_repeat is tied to 0.
module keypad_encoder #(
    parameter int DEBOUNCE_MS  = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int CNT_W        = 10
) (
    input logic              clk,
    input logic              rst,
    keypad_encoder_if.master bus
);

    // A bad parameter set must stop elaboration rather than build a counter that wraps.
    if (DEBOUNCE_MS < 2 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_MS) ||
        (64'd1 << CNT_W) <= 64'(REPEAT_DELAY) ||
        (64'd1 << CNT_W) <= 64'(REPEAT_RATE)) begin : gBadConfig
        $error("keypad_encoder: CNT_W too small for the counters or DEBOUNCE_MS < 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);

    state_t           state_q, state_d;
    logic [9:0]       syncMeta_q;
    logic [9:0]       ks_q;
    logic [9:0]       cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       keypad_q, keypad_d;
    logic             keyValid_q, keyValid_d;
    logic [3:0]       keyCode_q, keyCode_d;
    logic             keyHeld_q, keyHeld_d;
    logic             multiErr_q, multiErr_d;
    logic [3:0]       capIndex;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] rptCnt_q, rptCnt_d;
    logic             rptArmed_q, rptArmed_d;
    logic             keyRepeat_q, keyRepeat_d;
`endif

    // Convert the captured one-hot key to its BCD index for key_code.
    always_comb begin
        capIndex = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (cap_q[i]) begin
                capIndex = 4'(i);
            end
        end
    end

    // Next-state and output decisions. All decisions use the synchronized sample ks_q.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        keypad_d   = '0;
        keyValid_d = 1'b0;
        keyCode_d  = keyCode_q;
        keyHeld_d  = keyHeld_q;
        multiErr_d = ($countones(ks_q) > 1);
`ifdef KEYPAD_REPEAT_EN
        rptCnt_d    = rptCnt_q;
        rptArmed_d  = rptArmed_q;
        keyRepeat_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if ($onehot(ks_q)) begin
                    cap_d   = ks_q;
                    cnt_d   = CNT_W'(1);
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (ks_q != cap_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    cnt_d      = '0;
                    keypad_d   = cap_q;
                    keyValid_d = 1'b1;
                    keyCode_d  = capIndex;
                    keyHeld_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (ks_q != cap_q) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    keyHeld_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
                    rptCnt_d   = '0;
                    rptArmed_d = 1'b0;
`endif
                end else begin
                    keyHeld_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                    if ((!rptArmed_q && rptCnt_q == RPT_DELAY_LAST) ||
                        (rptArmed_q && rptCnt_q == RPT_RATE_LAST)) begin
                        rptCnt_d    = '0;
                        rptArmed_d  = 1'b1;
                        keypad_d    = cap_q;
                        keyValid_d  = 1'b1;
                        keyRepeat_d = 1'b1;
                    end else begin
                        rptCnt_d = rptCnt_q + CNT_W'(1);
                    end
`endif
                end
            end

            RELEASE: begin
                if (ks_q == '0) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Synchronizer flops and all state registers. Reset has priority even in the middle of a press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            syncMeta_q <= '0;
            ks_q       <= '0;
            state_q    <= IDLE;
            cap_q      <= '0;
            cnt_q      <= '0;
            keypad_q   <= '0;
            keyValid_q <= 1'b0;
            keyCode_q  <= 4'd0;
            keyHeld_q  <= 1'b0;
            multiErr_q <= 1'b0;
        end else begin
            syncMeta_q <= bus.key_raw;
            ks_q       <= syncMeta_q;
            state_q    <= state_d;
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            keypad_q   <= keypad_d;
            keyValid_q <= keyValid_d;
            keyCode_q  <= keyCode_d;
            keyHeld_q  <= keyHeld_d;
            multiErr_q <= multiErr_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat counter. It runs only while a press is held and clears when the press ends.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptCnt_q    <= '0;
            rptArmed_q  <= 1'b0;
            keyRepeat_q <= 1'b0;
        end else begin
            rptCnt_q    <= rptCnt_d;
            rptArmed_q  <= rptArmed_d;
            keyRepeat_q <= keyRepeat_d;
        end
    end

    assign bus.key_repeat = keyRepeat_q;
`else
    assign bus.key_repeat = 1'b0;
`endif

    assign bus.keypad    = keypad_q;
    assign bus.key_valid = keyValid_q;
    assign bus.key_code  = keyCode_q;
    assign bus.key_held  = keyHeld_q;
    assign bus.multi_err = multiErr_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder. The bench keeps a behavioural model of the
// key events and compares it with the DUT on every cycle. Directed scenarios
// also pin event timing and codes to hand-computed values.
module tb_keypad_encoder;

    localparam int DB  = 20;
    localparam int RD  = 500;
    localparam int RR  = 100;

    logic clk;
    logic rst;
    int   cyc;
    int   checkCount;
    int   passCount;
    int   failPrints;
    bit   checkEn;

    keypad_encoder_if bus ();

    keypad_encoder #(
        .DEBOUNCE_MS (DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .CNT_W       (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count active edges so that event times can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model. Phases: 0 waiting for a key, 1 key qualifying,
    // 2 key accepted and held, 3 waiting for a qualified release.
    int         phase;
    logic [9:0] mS1, mKs, seen, target;
    int         run, zeros, heldFor, ones;
    logic [9:0] mKeypad;
    logic [3:0] mCode;
    logic       mValid, mHeld, mRepeat, mMulti;

    always @(posedge clk) begin
        if (!rst) begin
            mS1 = '0; mKs = '0; phase = 0; target = '0;
            run = 0; zeros = 0; heldFor = 0;
            mKeypad = '0; mCode = '0; mValid = 0; mHeld = 0; mRepeat = 0; mMulti = 0;
        end else begin
            seen = mKs;
            mKs  = mS1;
            mS1  = bus.key_raw;
            ones = 0;
            for (int i = 0; i < 10; i++) ones += int'(seen[i]);
            mMulti  = (ones > 1);
            mKeypad = '0;
            mValid  = 0;
            mRepeat = 0;
            case (phase)
                0: if (ones == 1) begin
                    target = seen;
                    run    = 1;
                    phase  = 1;
                end
                1: if (seen != target) begin
                    phase = 0;
                end else begin
                    run++;
                    if (run == DB) begin
                        phase   = 2;
                        heldFor = 0;
                        mKeypad = target;
                        mValid  = 1;
                        mHeld   = 1;
                        for (int i = 0; i < 10; i++) if (target[i]) mCode = 4'(i);
                    end
                end
                2: if (seen != target) begin
                    phase = 3;
                    zeros = 0;
                    mHeld = 0;
                end else begin
                    heldFor++;
`ifdef KEYPAD_REPEAT_EN
                    if (heldFor == RD || (heldFor > RD && (heldFor - RD) % RR == 0)) begin
                        mKeypad = target;
                        mValid  = 1;
                        mRepeat = 1;
                    end
`endif
                end
                default: if (seen == 0) begin
                    zeros++;
                    if (zeros == DB) phase = 0;
                end else begin
                    zeros = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkCount++;
            if ({bus.keypad, bus.key_code, bus.key_valid, bus.key_held, bus.key_repeat, bus.multi_err} ===
                {mKeypad, mCode, mValid, mHeld, mRepeat, mMulti}) begin
                passCount++;
            end else if (failPrints < 20) begin
                failPrints++;
                $display("[TB] FAIL model cyc=%0d got kp=%h code=%0d v=%b h=%b r=%b m=%b want kp=%h code=%0d v=%b h=%b r=%b m=%b",
                         cyc, bus.keypad, bus.key_code, bus.key_valid, bus.key_held, bus.key_repeat, bus.multi_err,
                         mKeypad, mCode, mValid, mHeld, mRepeat, mMulti);
            end
        end
    end

    // Event log used by the directed checks.
    int         evCount;
    int         evCyc [64];
    logic [9:0] evKey [64];
    logic [3:0] evCode[64];
    int         repCount;

    always @(negedge clk) begin
        if (checkEn && bus.keypad != '0) begin
            if (evCount < 64) begin
                evCyc[evCount]  = cyc;
                evKey[evCount]  = bus.keypad;
                evCode[evCount] = bus.key_code;
            end
            evCount++;
            if (bus.key_repeat) repCount++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [9:0] raw, input logic rstVal, input int n);
        bus.key_raw = raw;
        rst         = rstVal;
        step(n);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    int base;
    int t0;

    initial begin
        cyc = 0; checkCount = 0; passCount = 0; failPrints = 0; checkEn = 0;
        evCount = 0; repCount = 0;
        bus.key_raw = 10'h004;
        rst         = 1'b0;

        // Reset held for 3 cycles with key 2 pressed.
        step(1);
        checkEn = 1;
        step(2);
        checkOutput("reset_keypad", int'(bus.keypad), 0);
        checkOutput("reset_code", int'(bus.key_code), 0);
        checkOutput("reset_held_valid_multi", int'({bus.key_held, bus.key_valid, bus.multi_err}), 0);
        base = evCount; t0 = cyc;
        applyStimulus(10'h004, 1'b1, 25);
        checkOutput("rst_ev_count", evCount - base, 1);
        checkOutput("rst_ev_latency", evCyc[base] - t0, 22);
        checkOutput("rst_ev_key", int'(evKey[base]), 'h004);
        checkOutput("rst_ev_code", int'(evCode[base]), 2);
        applyStimulus(10'h000, 1'b1, 30);

        // Long press of key 5, then release, a re-press just after release qualifies, and one just before.
        base = evCount; t0 = cyc;
        applyStimulus(10'h020, 1'b1, 200);
        checkOutput("k5_ev_count", evCount - base, 1);
        checkOutput("k5_ev_latency", evCyc[base] - t0, 22);
        checkOutput("k5_ev_code", int'(evCode[base]), 5);
        checkOutput("k5_held", int'(bus.key_held), 1);
        applyStimulus(10'h000, 1'b1, 2);
        checkOutput("k5_held_before_drop", int'(bus.key_held), 1);
        step(1);
        checkOutput("k5_held_after_drop", int'(bus.key_held), 0);
        step(18);
        t0 = cyc;
        applyStimulus(10'h020, 1'b1, 30);
        checkOutput("k5_repress_count", evCount - base, 2);
        checkOutput("k5_repress_latency", evCyc[base + 1] - t0, 22);
        applyStimulus(10'h000, 1'b1, 20);
        applyStimulus(10'h020, 1'b1, 40);
        checkOutput("k5_early_repress_count", evCount - base, 2);
        applyStimulus(10'h000, 1'b1, 30);

        // Bouncing key 3, then stable.
        base = evCount;
        for (int i = 0; i < 12; i++) applyStimulus((i % 2 == 0) ? 10'h008 : 10'h000, 1'b1, 5);
        checkOutput("bounce_no_event", evCount - base, 0);
        t0 = cyc;
        applyStimulus(10'h008, 1'b1, 40);
        checkOutput("bounce_ev_count", evCount - base, 1);
        checkOutput("bounce_ev_latency", evCyc[base] - t0, 22);
        checkOutput("bounce_ev_code", int'(evCode[base]), 3);
        applyStimulus(10'h000, 1'b1, 30);

        // Two keys together, then one of them alone.
        base = evCount;
        applyStimulus(10'h003, 1'b1, 2);
        checkOutput("multi_cycle2", int'(bus.multi_err), 0);
        step(1);
        checkOutput("multi_cycle3", int'(bus.multi_err), 1);
        step(47);
        checkOutput("multi_no_event", evCount - base, 0);
        t0 = cyc;
        applyStimulus(10'h001, 1'b1, 2);
        checkOutput("multi_still_set", int'(bus.multi_err), 1);
        step(1);
        checkOutput("multi_cleared", int'(bus.multi_err), 0);
        step(27);
        checkOutput("k0_ev_count", evCount - base, 1);
        checkOutput("k0_ev_latency", evCyc[base] - t0, 22);
        checkOutput("k0_ev_code", int'(evCode[base]), 0);
        applyStimulus(10'h000, 1'b1, 30);

        // Second key added while key 9 is held.
        base = evCount;
        applyStimulus(10'h200, 1'b1, 22);
        checkOutput("k9_ev_count", evCount - base, 1);
        step(10);
        applyStimulus(10'h201, 1'b1, 2);
        checkOutput("k9_held_before", int'(bus.key_held), 1);
        step(1);
        checkOutput("k9_held_dropped", int'(bus.key_held), 0);
        step(40);
        applyStimulus(10'h200, 1'b1, 40);
        checkOutput("k9_no_second_event", evCount - base, 1);
        checkOutput("k9_code_kept", int'(bus.key_code), 9);
        applyStimulus(10'h000, 1'b1, 30);
        t0 = cyc;
        applyStimulus(10'h040, 1'b1, 30);
        checkOutput("k6_after_release", evCount - base, 2);
        checkOutput("k6_latency", evCyc[base + 1] - t0, 22);
        checkOutput("k6_code", int'(evCode[base + 1]), 6);
        applyStimulus(10'h000, 1'b1, 30);

        // Key 7 held for 800 cycles.
        base = evCount; t0 = repCount;
        applyStimulus(10'h080, 1'b1, 800);
`ifdef KEYPAD_REPEAT_EN
        checkOutput("k7_ev_count", evCount - base, 4);
        checkOutput("k7_rep_count", repCount - t0, 3);
        checkOutput("k7_rep1", evCyc[base + 1] - evCyc[base], 500);
        checkOutput("k7_rep2", evCyc[base + 2] - evCyc[base], 600);
        checkOutput("k7_rep3", evCyc[base + 3] - evCyc[base], 700);
        checkOutput("k7_rep_code", int'(evCode[base + 3]), 7);
`else
        checkOutput("k7_ev_count", evCount - base, 1);
        checkOutput("k7_rep_count", repCount - t0, 0);
        checkOutput("k7_code", int'(evCode[base]), 7);
`endif
        applyStimulus(10'h000, 1'b1, 30);

        checkEn = 0;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
